// File: rtl/text_mode_pkg.sv
// text_mode_pkg: shared text-mode geometry and text-RAM address width
package text_mode_pkg;
   localparam int COLS = 80;
   localparam int ROWS = 30;
   localparam int CELL_W = 8;
   localparam int CELL_H = 16;
   localparam int H_MAX = 799;
   localparam int V_MAX = 524;
   localparam int H_DISPLAY = 640;
   localparam int V_DISPLAY = 480;
   localparam int ADDR_W = 12;
   typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/text_addr_gen.sv
// text_addr_gen: video fetch slot, fetch address and upcoming-cell visibility from the beam position
module text_addr_gen #(
   parameter int COLS = text_mode_pkg::COLS,
   parameter int CELL_W = text_mode_pkg::CELL_W,
   parameter int CELL_H = text_mode_pkg::CELL_H,
   parameter int H_MAX = text_mode_pkg::H_MAX,
   parameter int V_MAX = text_mode_pkg::V_MAX,
   parameter int H_DISPLAY = text_mode_pkg::H_DISPLAY,
   parameter int V_DISPLAY = text_mode_pkg::V_DISPLAY
) (
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   output logic slot,
   output text_mode_pkg::addr_t addr,
   output logic vis
);
   localparam int CB = $clog2(CELL_W);
   localparam int RB = $clog2(CELL_H);
   localparam int AW = text_mode_pkg::ADDR_W;
   logic [9:0] next_line;
   logic in_line, col0;
   logic [8-RB:0] row;
   logic [9-CB:0] col;
   always_comb begin
      next_line = (vpos == 10'(V_MAX)) ? 10'd0 : vpos + 10'd1;
      in_line = hpos[CB-1:0] == CB'(CELL_W / 2) && hpos < 10'(H_DISPLAY - CELL_W);
      // column 0 of the next line is prefetched in the tail of horizontal blanking
      col0 = hpos == 10'(H_MAX - 3) && next_line < 10'(V_DISPLAY);
      slot = in_line | col0;
      row = col0 ? next_line[8:RB] : vpos[8:RB];
      col = col0 ? '0 : hpos[9:CB] + (10 - CB)'(1);
      addr = AW'(row) * AW'(COLS) + AW'(col);
      vis = (hpos == 10'(H_MAX)) ? next_line < 10'(V_DISPLAY)
                                 : (hpos + 10'd1 < 10'(H_DISPLAY)) && vpos < 10'(V_DISPLAY);
   end
endmodule

// File: rtl/text_fetch_scheduler.sv
// text_fetch_scheduler: arbitrates text RAM between video prefetch and host, and drives the character stream
module text_fetch_scheduler #(
   parameter int COLS = text_mode_pkg::COLS,
   parameter int ROWS = text_mode_pkg::ROWS,
   parameter int CELL_W = text_mode_pkg::CELL_W,
   parameter int CELL_H = text_mode_pkg::CELL_H,
   parameter int H_MAX = text_mode_pkg::H_MAX,
   parameter int V_MAX = text_mode_pkg::V_MAX
) (
   input  logic clk,
   input  logic reset,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic host_req,
   input  logic host_we,
   input  logic [11:0] host_addr,
   input  logic [7:0] host_wdata,
   output logic host_ack,
   output logic [7:0] host_rdata,
   output logic [11:0] mem_addr,
   output logic mem_we,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [7:0] char_code,
   output logic char_valid
);
   localparam int CB = $clog2(CELL_W);
   logic slot, vis, vid, accept;
   text_mode_pkg::addr_t fetch_addr;
   logic slot_q, ack_q, rd_q, valid_q;
   logic [7:0] fetch_buf, rd_hold, code_q;
   text_addr_gen #(
      .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H), .H_MAX(H_MAX), .V_MAX(V_MAX),
      .H_DISPLAY(COLS * CELL_W), .V_DISPLAY(ROWS * CELL_H)
   ) u_addr_gen (
      .hpos(hpos), .vpos(vpos), .slot(slot), .addr(fetch_addr), .vis(vis)
   );
   // reset masks outputs in the same cycle so a pending ack or write never escapes
   always_comb begin
      vid = slot & ~reset;
      host_ack = ack_q & ~reset;
      accept = host_req & ~slot & ~host_ack & ~reset;
      host_rdata = reset ? 8'd0 : (host_ack & rd_q) ? mem_rdata : rd_hold;
      mem_addr = vid ? fetch_addr : accept ? host_addr : 12'd0;
      mem_we = accept & host_we;
      mem_wdata = accept ? host_wdata : 8'd0;
      char_code = reset ? 8'd0 : code_q;
      char_valid = valid_q & ~reset;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= 1'b0;
         ack_q <= 1'b0;
         rd_q <= 1'b0;
         fetch_buf <= 8'd0;
         rd_hold <= 8'd0;
         code_q <= 8'd0;
         valid_q <= 1'b0;
      end else begin
         slot_q <= vid;
         ack_q <= accept;
         rd_q <= accept & ~host_we;
         if (slot_q) fetch_buf <= mem_rdata;
         if (host_ack & rd_q) rd_hold <= mem_rdata;
         if (hpos[CB-1:0] == '1) begin
            valid_q <= vis;
            code_q <= vis ? fetch_buf : 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_text_fetch_scheduler.sv
// tb_text_fetch_scheduler: directed bench with a synchronous RAM model and a loadable 800x525 beam counter
module tb_text_fetch_scheduler;
   logic clk = 1'b0;
   logic reset;
   logic [9:0] hpos, vpos;
   logic host_req, host_we;
   logic [11:0] host_addr;
   logic [7:0] host_wdata;
   logic host_ack;
   logic [7:0] host_rdata;
   logic [11:0] mem_addr;
   logic mem_we;
   logic [7:0] mem_wdata, mem_rdata, char_code;
   logic char_valid;
   logic [7:0] ram [4096];
   logic [7:0] model [4096];
   int checks = 0, errors = 0;
   bit s, acc, prev;
   int ea;

   always #5 clk = ~clk;

   text_fetch_scheduler dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .char_code(char_code), .char_valid(char_valid)
   );

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = i[7:0];
      forever begin
         @(posedge clk);
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (hpos == 10'd799) begin
         hpos = 10'd0;
         vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
      end else hpos = hpos + 10'd1;
      #1;
   endtask

   task automatic goto(input int h, input int v);
      hpos = h[9:0];
      vpos = v[9:0];
      #1;
   endtask

   task automatic tick_to(input int h);
      for (int n = 0; n < 1000 && int'(hpos) != h; n++) tick();
      chk("reach_hpos", 32'(hpos), h);
   endtask

   function automatic bit exp_slot(input int h, input int v);
      return (h % 8 == 4 && h < 632) || (h == 796 && (v < 479 || v == 524));
   endfunction

   function automatic int exp_addr(input int h, input int v);
      int nl;
      nl = (v == 524) ? 0 : v + 1;
      return (h == 796) ? (nl / 16) * 80 : ((v % 512) / 16) * 80 + h / 8 + 1;
   endfunction

   function automatic int exp_cell(input int h, input int v);
      return (h < 640 && v < 480) ? int'(model[(v / 16) * 80 + h / 8]) : 0;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) model[i] = i[7:0];
      reset = 1'b1; hpos = 10'd0; vpos = 10'd0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 12'd0; host_wdata = 8'd0;
      tick(); tick();
      chk("rst_ack", 32'(host_ack), 0);
      chk("rst_rdata", 32'(host_rdata), 0);
      chk("rst_code", 32'(char_code), 0);
      chk("rst_valid", 32'(char_valid), 0);
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      tick(); tick();
      chk("rst_slot_addr", 32'(mem_addr), 0);
      // first visible frame region: column-0 prefetch then in-line fetches
      reset = 1'b0;
      goto(796, 16);
      chk("col0_addr", 32'(mem_addr), 80);
      chk("col0_we", 32'(mem_we), 0);
      tick_to(0);
      chk("col0_code", 32'(char_code), 32'h50);
      chk("col0_valid", 32'(char_valid), 1);
      tick_to(4);
      chk("slot_addr", 32'(mem_addr), 81);
      tick_to(8);
      chk("cell1_code", 32'(char_code), 32'h51);
      chk("cell1_valid", 32'(char_valid), 1);
      tick_to(632);
      chk("cell79_code", 32'(char_code), 32'h9f);
      chk("cell79_valid", 32'(char_valid), 1);
      tick_to(640);
      chk("hblank_valid", 32'(char_valid), 0);
      chk("hblank_code", 32'(char_code), 0);
      // no prefetch for line 480, prefetch for line 0 after V_MAX
      goto(796, 479);
      chk("v479_addr", 32'(mem_addr), 0);
      tick_to(0);
      chk("v480_valid", 32'(char_valid), 0);
      goto(796, 524);
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'h300; host_wdata = 8'h11;
      #1;
      chk("wrap_addr", 32'(mem_addr), 0);
      chk("wrap_we", 32'(mem_we), 0);
      chk("wrap_ack", 32'(host_ack), 0);
      tick();
      chk("wrap_host_we", 32'(mem_we), 1);
      chk("wrap_host_addr", 32'(mem_addr), 32'h300);
      chk("wrap_host_wdata", 32'(mem_wdata), 32'h11);
      model[12'h300] = 8'h11;
      tick();
      chk("wrap_host_ack", 32'(host_ack), 1);
      host_req = 1'b0;
      tick_to(0);
      chk("v0_valid", 32'(char_valid), 1);
      chk("v0_code", 32'(char_code), 0);
      tick_to(8);
      chk("v0_cell1", 32'(char_code), 1);
      // host write colliding with a video slot, then read-back and hold
      goto(4, 20);
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'h123; host_wdata = 8'ha5;
      #1;
      chk("w_slot_we", 32'(mem_we), 0);
      chk("w_slot_addr", 32'(mem_addr), 81);
      chk("w_slot_ack", 32'(host_ack), 0);
      tick();
      chk("w_we", 32'(mem_we), 1);
      chk("w_addr", 32'(mem_addr), 32'h123);
      chk("w_wdata", 32'(mem_wdata), 32'ha5);
      chk("w_ack_early", 32'(host_ack), 0);
      model[12'h123] = 8'ha5;
      tick();
      chk("w_ack", 32'(host_ack), 1);
      chk("w_ack_we", 32'(mem_we), 0);
      chk("w_rdata_hold", 32'(host_rdata), 0);
      host_req = 1'b0;
      tick();
      host_req = 1'b1; host_we = 1'b0;
      #1;
      chk("r_addr", 32'(mem_addr), 32'h123);
      chk("r_we", 32'(mem_we), 0);
      tick();
      chk("r_ack", 32'(host_ack), 1);
      chk("r_rdata", 32'(host_rdata), 32'ha5);
      chk("r_code", 32'(char_code), 32'h51);
      host_req = 1'b0;
      tick();
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'h124; host_wdata = 8'h3c;
      #1;
      chk("w2_we", 32'(mem_we), 1);
      model[12'h124] = 8'h3c;
      tick();
      chk("w2_ack", 32'(host_ack), 1);
      chk("w2_rdata_hold", 32'(host_rdata), 32'ha5);
      host_req = 1'b0;
      tick();
      // continuously held read across in-line and column-0 slots
      goto(600, 47);
      host_req = 1'b1; host_we = 1'b0; host_addr = 12'h123;
      #1;
      prev = 1'b0;
      for (int i = 0; i < 260; i++) begin
         s = exp_slot(int'(hpos), int'(vpos));
         acc = !s && !prev;
         ea = s ? exp_addr(int'(hpos), int'(vpos)) : acc ? 32'h123 : 0;
         chk("hold_ack", 32'(host_ack), 32'(prev));
         chk("hold_addr", 32'(mem_addr), ea);
         chk("hold_we", 32'(mem_we), 0);
         if (prev) chk("hold_rdata", 32'(host_rdata), 32'(model[12'h123]));
         if (i >= 12 && hpos[2:0] == 3'd0) begin
            chk("hold_valid", 32'(char_valid), (hpos < 10'd640 && vpos < 10'd480) ? 1 : 0);
            chk("hold_code", 32'(char_code), exp_cell(int'(hpos), int'(vpos)));
         end
         prev = acc;
         tick();
      end
      host_req = 1'b0;
      tick(); tick();
      // reset lands on the ack cycle of an accepted write
      goto(9, 64);
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'h200; host_wdata = 8'h77;
      #1;
      chk("rw_we", 32'(mem_we), 1);
      model[12'h200] = 8'h77;
      tick();
      reset = 1'b1;
      #1;
      chk("rw_ack", 32'(host_ack), 0);
      chk("rw_we_rst", 32'(mem_we), 0);
      chk("rw_addr_rst", 32'(mem_addr), 0);
      chk("rw_code", 32'(char_code), 0);
      chk("rw_valid", 32'(char_valid), 0);
      chk("rw_rdata", 32'(host_rdata), 0);
      tick();
      reset = 1'b0; host_req = 1'b0;
      #1;
      chk("post_ack", 32'(host_ack), 0);
      chk("post_code", 32'(char_code), 0);
      chk("post_valid", 32'(char_valid), 0);
      tick_to(15);
      chk("post15_code", 32'(char_code), 0);
      tick_to(16);
      chk("resume_code", 32'(char_code), 32'h42);
      chk("resume_valid", 32'(char_valid), 1);
      tick_to(24);
      chk("resume_code2", 32'(char_code), 32'h43);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
